// File: rtl/game_irq_arbiter_if.sv
// Bundle between the game event sources / CPU and the interrupt arbiter.
// master drives requests, mask, ack and clear; slave returns irq, cause and status.
interface game_irq_arbiter_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned CAUSE_W = 2
);
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] mask;
    logic               ack;
    logic               ovf_clr;
    logic               irq;
    logic [CAUSE_W-1:0] irq_cause;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] overrun;
    logic               timeout_flag;

    modport master (
        output req, mask, ack, ovf_clr,
        input  irq, irq_cause, pending, overrun, timeout_flag
    );

    modport slave (
        input  req, mask, ack, ovf_clr,
        output irq, irq_cause, pending, overrun, timeout_flag
    );
endinterface

// File: rtl/game_irq_arbiter.sv
// Shares the CPU key_interrupt line among edge-triggered game event sources,
// with round-robin selection, ack handshake, timeout withdrawal and overrun tracking.
module game_irq_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned CAUSE_W = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                clock,
    input  logic                reset,
    game_irq_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [NUM_SRC-1:0] req_d;
    logic [NUM_SRC-1:0] evt;
    logic [NUM_SRC-1:0] elig;
    logic [NUM_SRC-1:0] clr_vec;
    logic [NUM_SRC-1:0] ovr_set;
    logic [NUM_SRC-1:0] pending_q, pending_nxt;
    logic [NUM_SRC-1:0] overrun_q, overrun_nxt;
    logic [CAUSE_W-1:0] last_q, last_nxt;
    logic [CAUSE_W-1:0] cause_q, cause_nxt;
    logic [CAUSE_W-1:0] grant_idx;
    logic [CAUSE_W-1:0] cand;
    logic               grant_vld;
    logic               irq_q, irq_nxt;
    logic               tf_q, tf_nxt;
    logic               to_set;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    int unsigned        rr_idx;

    assign evt  = bus.req & ~req_d;
    assign elig = pending_q & bus.mask;

    // Round-robin search starting one past the last granted source.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        cand      = '0;
        for (int unsigned off = 1; off <= NUM_SRC; off++) begin
            rr_idx = 32'(last_q) + off;
            if (rr_idx >= NUM_SRC) begin
                rr_idx = rr_idx - NUM_SRC;
            end
            cand = CAUSE_W'(rr_idx);
            if (!grant_vld && elig[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        irq_nxt   = irq_q;
        cause_nxt = cause_q;
        last_nxt  = last_q;
        cnt_nxt   = cnt_q;
        clr_vec   = '0;
        to_set    = 1'b0;

        case (state)
            S_IDLE: begin
                if (grant_vld) begin
                    cause_nxt = grant_idx;
                    last_nxt  = grant_idx;
                    irq_nxt   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.ack) begin
                    clr_vec[cause_q] = 1'b1;
                    irq_nxt          = 1'b0;
                    state_nxt        = S_GAP;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    irq_nxt   = 1'b0;
                    to_set    = 1'b1;
                    state_nxt = S_GAP;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                irq_nxt   = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                irq_nxt   = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase

        // A new event beats a same-cycle clear and is then not an overrun.
        ovr_set     = evt & pending_q & ~clr_vec;
        pending_nxt = (pending_q & ~clr_vec) | evt;
        overrun_nxt = (bus.ovf_clr ? {NUM_SRC{1'b0}} : overrun_q) | ovr_set;
        tf_nxt      = (bus.ovf_clr ? 1'b0 : tf_q) | to_set;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            req_d     <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            last_q    <= '0;
            cause_q   <= '0;
            irq_q     <= 1'b0;
            tf_q      <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nxt;
            req_d     <= bus.req;
            pending_q <= pending_nxt;
            overrun_q <= overrun_nxt;
            last_q    <= last_nxt;
            cause_q   <= cause_nxt;
            irq_q     <= irq_nxt;
            tf_q      <= tf_nxt;
            cnt_q     <= cnt_nxt;
        end
    end

    assign bus.irq          = irq_q;
    assign bus.irq_cause    = cause_q;
    assign bus.pending      = pending_q;
    assign bus.overrun      = overrun_q;
    assign bus.timeout_flag = tf_q;

endmodule
